// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the master and its users.
//   AXIL_ADDR_W / AXIL_DATA_W : default address and data widths
//   RESP_*                    : AXI response codes
//   wr_state_t / rd_state_t   : write and read FSM state encodings
package axil_pkg;

   localparam int unsigned AXIL_ADDR_W = 32;
   localparam int unsigned AXIL_DATA_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef logic [1:0] wr_state_t;
   localparam wr_state_t W_IDLE = 2'd0;
   localparam wr_state_t W_AD   = 2'd1;
   localparam wr_state_t W_B    = 2'd2;

   typedef logic [1:0] rd_state_t;
   localparam rd_state_t R_IDLE = 2'd0;
   localparam rd_state_t R_A    = 2'd1;
   localparam rd_state_t R_D    = 2'd2;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. Converts one-word application
// write/read requests into AXI4-Lite transactions; write and read paths are
// independent and may be in flight together.
// Ports:
//   aclk, reset          : clock, asynchronous active-high reset
//   m_axi_aw*/w*/b*      : AXI write address, data and response channels
//   m_axi_ar*/r*         : AXI read address and data channels
//   app_waddr/app_wdata  : write request payload, taken with app_wen when idle
//   app_wen / app_wdone  : write start / one-cycle completion pulse
//   app_raddr            : read address, taken with app_ren when idle
//   app_ren / app_rdone  : read start (level) / one-cycle completion pulse
//   app_rdata            : last read data, valid with app_rdone and held
module axi_lite_master
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W = AXIL_ADDR_W,
   parameter int unsigned DATA_W = AXIL_DATA_W
) (
   input  logic                  aclk,
   input  logic                  reset,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   input  logic [ADDR_W-1:0]     app_waddr,
   input  logic [DATA_W-1:0]     app_wdata,
   input  logic                  app_wen,
   output logic                  app_wdone,
   input  logic [ADDR_W-1:0]     app_raddr,
   input  logic                  app_ren,
   output logic [DATA_W-1:0]     app_rdata,
   output logic                  app_rdone
);

   wr_state_t wr_state;
   rd_state_t rd_state;

   logic aw_done;
   logic w_done;

   // Response codes never affect completion; they are intentionally dropped.
   logic resp_unused;
   assign resp_unused = ^{m_axi_bresp, m_axi_rresp,
                          RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = '1;

   // A channel counts as done once its valid has already dropped or its
   // handshake completes this cycle, so AW and W may finish in any order.
   assign aw_done = !m_axi_awvalid || m_axi_awready;
   assign w_done  = !m_axi_wvalid  || m_axi_wready;

   // Write path
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         wr_state      <= W_IDLE;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         app_wdone     <= 1'b0;
      end else begin
         app_wdone <= 1'b0;
         case (wr_state)
            W_IDLE: begin
               if (app_wen) begin
                  m_axi_awaddr  <= app_waddr;
                  m_axi_wdata   <= app_wdata;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  wr_state      <= W_AD;
               end
            end
            W_AD: begin
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  wr_state     <= W_B;
               end
            end
            W_B: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  app_wdone    <= 1'b1;
                  wr_state     <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Read path
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         rd_state      <= R_IDLE;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         app_rdata     <= '0;
         app_rdone     <= 1'b0;
      end else begin
         app_rdone <= 1'b0;
         case (rd_state)
            R_IDLE: begin
               if (app_ren) begin
                  m_axi_araddr  <= app_raddr;
                  m_axi_arvalid <= 1'b1;
                  rd_state      <= R_A;
               end
            end
            R_A: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  rd_state      <= R_D;
               end
            end
            R_D: begin
               if (m_axi_rvalid) begin
                  app_rdata    <= m_axi_rdata;
                  m_axi_rready <= 1'b0;
                  app_rdone    <= 1'b1;
                  rd_state     <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a configurable-latency AXI slave,
// a timing model that predicts every master output per cycle from the
// request time and slave wait settings, and directed scenarios with
// hand-computed latency and data expectations.
module tb_axi_lite_master;

   logic        aclk = 1'b0;
   logic        reset;
   logic [31:0] awaddr, wdata, araddr, rdata, app_waddr, app_wdata, app_raddr, app_rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic        app_wen, app_wdone, app_ren, app_rdone;

   always #5 aclk = ~aclk;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .aclk(aclk), .reset(reset),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .app_waddr(app_waddr), .app_wdata(app_wdata), .app_wen(app_wen), .app_wdone(app_wdone),
      .app_raddr(app_raddr), .app_ren(app_ren), .app_rdata(app_rdata), .app_rdone(app_rdone)
   );

   // ---------------- slave configuration and behaviour ----------------
   int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] rd_key = '0;

   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_hs_cnt;
   logic        aw_got, w_got, ar_got;
   logic [31:0] ar_cap, sl_awaddr, sl_wdata;
   logic        aw_hs, w_hs, ar_hs;

   // Ready rises after the configured number of cycles of valid.
   assign awready = awvalid && (aw_cnt == aw_wait);
   assign wready  = wvalid  && (w_cnt  == w_wait);
   assign arready = arvalid && (ar_cnt == ar_wait);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid  && wready;
   assign ar_hs   = arvalid && arready;

   always @(posedge aclk or posedge reset) begin
      if (reset) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0; aw_hs_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; ar_cap <= '0;
         sl_awaddr <= '0; sl_wdata <= '0;
         bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (aw_hs) begin sl_awaddr <= awaddr; aw_hs_cnt <= aw_hs_cnt + 1; end
         if (w_hs)  sl_wdata <= wdata;
         if (bvalid) begin
            if (bready) bvalid <= 1'b0;
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
         end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            if (b_cnt == b_wait) begin
               bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else begin
               b_cnt <= b_cnt + 1; aw_got <= 1'b1; w_got <= 1'b1;
            end
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
         end
         if (rvalid) begin
            if (rready) rvalid <= 1'b0;
         end else if (ar_got || ar_hs) begin
            if (r_cnt == r_wait) begin
               rvalid <= 1'b1; rresp <= rresp_cfg; ar_got <= 1'b0; r_cnt <= 0;
               rdata  <= (ar_hs ? araddr : ar_cap) ^ rd_key;
            end else begin
               r_cnt <= r_cnt + 1; ar_got <= 1'b1;
               if (ar_hs) ar_cap <= araddr;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0, n_bad = 0;
   int e = 0;
   int wdone_cnt = 0, rdone_cnt = 0, last_wdone_e = 0, last_rdone_e = 0, prev_rdone_e = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %h expected %h", name, e, act, exp);
      end
   endtask

   // Transaction timing model. Edge numbers: t0 = edge the request is taken,
   // waits are slave stall cycles. Valid is up until its handshake edge, the
   // response ready follows the later address/data handshake, and the done
   // pulse appears after the response handshake edge.
   bit          w_act = 0, r_act = 0;
   int          w_t0, w_aw, w_w, w_h, w_d, r_t0, r_ar, r_a, r_d;
   logic [31:0] w_addr, w_data, r_addr, r_val, rdata_exp = '0;
   logic        exp_v;

   initial begin
      forever begin
         @(posedge aclk);
         e = e + 1;
         if (reset) begin
            w_act = 0; r_act = 0; rdata_exp = '0;
         end else begin
            if (w_act && e > w_d) w_act = 0;
            if (app_wen && !w_act) begin
               w_act = 1; w_t0 = e; w_addr = app_waddr; w_data = app_wdata;
               w_aw = aw_wait; w_w = w_wait;
               w_h = e + 1 + ((aw_wait > w_wait) ? aw_wait : w_wait);
               w_d = w_h + b_wait + 1;
            end
            if (r_act && e > r_d) r_act = 0;
            if (app_ren && !r_act) begin
               r_act = 1; r_t0 = e; r_addr = app_raddr; r_ar = ar_wait;
               r_a = e + 1 + ar_wait; r_d = r_a + r_wait + 1;
               r_val = app_raddr ^ rd_key;
            end
            if (r_act && e == r_d) rdata_exp = r_val;
         end
         #1;
         if (app_wdone) begin wdone_cnt++; last_wdone_e = e; end
         if (app_rdone) begin rdone_cnt++; prev_rdone_e = last_rdone_e; last_rdone_e = e; end
         exp_v = w_act && (e <= w_t0 + w_aw);
         chk("awvalid", {31'd0, awvalid}, {31'd0, exp_v});
         if (exp_v) chk("awaddr", awaddr, w_addr);
         exp_v = w_act && (e <= w_t0 + w_w);
         chk("wvalid", {31'd0, wvalid}, {31'd0, exp_v});
         if (exp_v) chk("wdata", wdata, w_data);
         chk("bready", {31'd0, bready}, {31'd0, w_act && e >= w_h && e < w_d});
         chk("app_wdone", {31'd0, app_wdone}, {31'd0, w_act && e == w_d});
         exp_v = r_act && (e <= r_t0 + r_ar);
         chk("arvalid", {31'd0, arvalid}, {31'd0, exp_v});
         if (exp_v) chk("araddr", araddr, r_addr);
         chk("rready", {31'd0, rready}, {31'd0, r_act && e >= r_a && e < r_d});
         chk("app_rdone", {31'd0, app_rdone}, {31'd0, r_act && e == r_d});
         chk("app_rdata", app_rdata, rdata_exp);
         chk("wstrb", {28'd0, wstrb}, 32'h0000_000F);
         chk("prot", {26'd0, awprot, arprot}, 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr_req(input logic [31:0] a, input logic [31:0] d, output int t);
      @(negedge aclk); app_waddr = a; app_wdata = d; app_wen = 1'b1;
      @(negedge aclk); app_wen = 1'b0; t = e;
   endtask

   task automatic rd_req(input logic [31:0] a, output int t);
      @(negedge aclk); app_raddr = a; app_ren = 1'b1;
      @(negedge aclk); app_ren = 1'b0; t = e;
   endtask

   task automatic wait_done(input string name, input int w_target, input int r_target);
      int n;
      n = 0;
      while ((wdone_cnt < w_target || rdone_cnt < r_target) && n < 50) begin
         @(negedge aclk); n++;
      end
      n_cmp++;
      if (wdone_cnt < w_target || rdone_cnt < r_target) begin
         n_bad++;
         $display("FAIL %s timeout: wdone %0d/%0d rdone %0d/%0d", name, wdone_cnt, w_target, rdone_cnt, r_target);
      end
   endtask

   task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
      aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
   endtask

   int t, t1, t2, wc, rc, hc;

   initial begin
      reset = 1'b1; app_wen = 1'b0; app_ren = 1'b0;
      app_waddr = '0; app_wdata = '0; app_raddr = '0;
      repeat (3) @(negedge aclk);
      chk("reset_rdata", app_rdata, 32'h0);
      chk("reset_valids", {28'd0, awvalid, wvalid, arvalid, bready}, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge aclk);

      // Zero-wait write: wdone in the third cycle after the wen cycle.
      set_waits(0, 0, 0, 0, 0);
      wc = wdone_cnt;
      wr_req(32'hAAAA_BBBB, 32'h5AA5_A55A, t);
      wait_done("wr_zero", wc + 1, rdone_cnt);
      chk("wr_zero_latency", last_wdone_e - t, 32'd2);
      chk("wr_zero_awaddr", sl_awaddr, 32'hAAAA_BBBB);
      chk("wr_zero_wdata", sl_wdata, 32'h5AA5_A55A);
      repeat (3) @(negedge aclk);
      chk("wr_zero_pulses", wdone_cnt - wc, 32'd1);

      // W accepted two cycles before AW.
      set_waits(2, 0, 0, 0, 0);
      wc = wdone_cnt;
      wr_req(32'h0000_1000, 32'h1111_2222, t);
      wait_done("wr_aw_late", wc + 1, rdone_cnt);
      chk("wr_aw_late_latency", last_wdone_e - t, 32'd4);

      // AW accepted three cycles before W; a second wen while busy is ignored.
      set_waits(0, 3, 0, 0, 0);
      wc = wdone_cnt; hc = aw_hs_cnt;
      wr_req(32'h0000_2000, 32'h3333_4444, t1);
      wr_req(32'h0000_3000, 32'h5555_6666, t2);
      wait_done("wr_w_late", wc + 1, rdone_cnt);
      chk("wr_w_late_latency", last_wdone_e - t1, 32'd5);
      repeat (4) @(negedge aclk);
      chk("wr_busy_pulses", wdone_cnt - wc, 32'd1);
      chk("wr_busy_aw_count", aw_hs_cnt - hc, 32'd1);
      chk("wr_busy_awaddr", sl_awaddr, 32'h0000_2000);

      // Slow write response.
      set_waits(1, 1, 2, 0, 0);
      wc = wdone_cnt;
      wr_req(32'h0000_4000, 32'h7777_8888, t);
      wait_done("wr_slow_b", wc + 1, rdone_cnt);
      chk("wr_slow_b_latency", last_wdone_e - t, 32'd5);

      // Read with two data wait cycles.
      set_waits(0, 0, 0, 0, 2);
      rd_key = 32'hAAAA_BBBB ^ 32'hDEAD_BEEF;
      rc = rdone_cnt;
      rd_req(32'hAAAA_BBBB, t);
      wait_done("rd_wait", wcdummy(), rc + 1);
      chk("rd_wait_latency", last_rdone_e - t, 32'd4);
      chk("rd_wait_data", app_rdata, 32'hDEAD_BEEF);
      repeat (3) @(negedge aclk);
      chk("rd_wait_hold", app_rdata, 32'hDEAD_BEEF);

      // Back-to-back reads with app_ren held high.
      set_waits(0, 0, 0, 0, 1);
      rd_key = 32'h0F0F_0000;
      rc = rdone_cnt;
      @(negedge aclk); app_raddr = 32'h0000_0100; app_ren = 1'b1;
      wait_done("rd_b2b", wdone_cnt, rc + 3);
      app_ren = 1'b0;
      chk("rd_b2b_spacing", last_rdone_e - prev_rdone_e, 32'd4);
      chk("rd_b2b_data", app_rdata, 32'h0F0F_0100);
      repeat (4) @(negedge aclk);
      chk("rd_b2b_count", rdone_cnt - rc, 32'd3);

      // Concurrent write and read with error responses.
      set_waits(1, 0, 1, 1, 0);
      bresp_cfg = 2'b10; rresp_cfg = 2'b11; rd_key = '0;
      wc = wdone_cnt; rc = rdone_cnt;
      @(negedge aclk);
      app_waddr = 32'h0000_5000; app_wdata = 32'h9999_AAAA; app_wen = 1'b1;
      app_raddr = 32'h1234_5678; app_ren = 1'b1;
      @(negedge aclk); app_wen = 1'b0; app_ren = 1'b0; t = e;
      wait_done("concurrent", wc + 1, rc + 1);
      chk("conc_wr_latency", last_wdone_e - t, 32'd4);
      chk("conc_rd_latency", last_rdone_e - t, 32'd3);
      chk("conc_rdata", app_rdata, 32'h1234_5678);
      bresp_cfg = 2'b00; rresp_cfg = 2'b00;
      repeat (2) @(negedge aclk);

      // Reset while awvalid is high aborts the write with no done pulse.
      set_waits(5, 5, 0, 0, 0);
      wc = wdone_cnt;
      wr_req(32'h0000_6000, 32'hBBBB_CCCC, t);
      chk("pre_reset_awvalid", {31'd0, awvalid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, app_wdone}, 32'd0);
      chk("async_reset_rdata", app_rdata, 32'd0);
      repeat (2) @(negedge aclk);
      reset = 1'b0;
      repeat (6) @(negedge aclk);
      chk("reset_no_wdone", wdone_cnt - wc, 32'd0);
      set_waits(0, 0, 0, 0, 0);
      wr_req(32'h0000_7000, 32'hDDDD_EEEE, t);
      wait_done("post_reset_wr", wc + 1, rdone_cnt);
      chk("post_reset_latency", last_wdone_e - t, 32'd2);
      chk("post_reset_awaddr", sl_awaddr, 32'h0000_7000);
      repeat (3) @(negedge aclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   function automatic int wcdummy();
      return wdone_cnt;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
